// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer
// Serialises one pair of 12-bit samples per valid/ready request into a
// dual-channel SPI-style DAC frame: 16 bits per channel, MSB first, with
// both data lines shifted together on a common SCLK.
// Frame word per channel: {2'b00, pd_mode, sample}.
//
// Ports:
//   clock     system clock, all logic on posedge
//   reset     synchronous active-high reset
//   sample_a  channel A sample (12 bit, unsigned)
//   sample_b  channel B sample (12 bit, unsigned)
//   pd_mode   DAC power-down bits, latched with the samples
//   valid     upstream request qualifier
//   ready     registered; high while idle and able to accept a request
//   done      one-cycle pulse on the cycle sync_n returns high
//   sync_n    DAC frame sync, active low
//   sclk      DAC serial clock, idles high; DAC samples on falling edges
//   dina      serial data, channel A
//   dinb      serial data, channel B
module dac_frame_serializer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic [1:0]  pd_mode,
  input  logic        valid,
  output logic        ready,
  output logic        done,
  output logic        sync_n,
  output logic        sclk,
  output logic        dina,
  output logic        dinb
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [WORD_W-1:0]   sh_a;
  logic [WORD_W-1:0]   sh_b;

  // Data lines are the MSB of the shift registers; the registers are
  // cleared outside a frame so the lines idle low without extra flops.
  assign dina = sh_a[WORD_W-1];
  assign dinb = sh_b[WORD_W-1];

  // Frame sequencer: IDLE -> SHIFT -> GAP -> IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      sync_n  <= 1'b1;
      sclk    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            state   <= SHIFT;
            ready   <= 1'b0;
            sync_n  <= 1'b0;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh_a    <= {2'b00, pd_mode, sample_a};
            sh_b    <= {2'b00, pd_mode, sample_b};
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Rising edge: present the next bit, or close the frame after
            // the 16th bit has been sampled.
            if (!sclk) begin
              if (bit_cnt == BIT_LAST) begin
                state   <= GAP;
                sync_n  <= 1'b1;
                sclk    <= 1'b1;
                done    <= 1'b1;
                gap_cnt <= '0;
                sh_a    <= '0;
                sh_b    <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                sh_a    <= {sh_a[WORD_W-2:0], 1'b0};
                sh_b    <= {sh_b[WORD_W-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Bench for dac_frame_serializer: two instances (CLK_DIV=4/GAP=2 and
// CLK_DIV=1/GAP=1) checked every cycle against a timing model derived from
// the frame rules, plus table vectors and hand-written corner sequences.
module tb_dac_frame_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst   [2];
  logic        valid [2];
  logic [11:0] sa    [2];
  logic [11:0] sb    [2];
  logic [1:0]  pd    [2];
  logic        rdy   [2];
  logic        dn    [2];
  logic        syn   [2];
  logic        sck   [2];
  logic        da    [2];
  logic        db    [2];

  dac_frame_serializer #(.CLK_DIV(4), .GAP_CYCLES(2)) u0 (
    .clock(clock), .reset(rst[0]), .sample_a(sa[0]), .sample_b(sb[0]),
    .pd_mode(pd[0]), .valid(valid[0]), .ready(rdy[0]), .done(dn[0]),
    .sync_n(syn[0]), .sclk(sck[0]), .dina(da[0]), .dinb(db[0]));

  dac_frame_serializer #(.CLK_DIV(1), .GAP_CYCLES(1)) u1 (
    .clock(clock), .reset(rst[1]), .sample_a(sa[1]), .sample_b(sb[1]),
    .pd_mode(pd[1]), .valid(valid[1]), .ready(rdy[1]), .done(dn[1]),
    .sync_n(syn[1]), .sclk(sck[1]), .dina(da[1]), .dinb(db[1]));

  int checks   = 0;
  int failures = 0;

  function automatic int dv(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gp(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, int d, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b exp=%b", nm, d, $time, got, exp);
    end
  endtask

  task automatic chkv(string nm, int d, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, d, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic ready;
    logic done;
    logic sync_n;
    logic sclk;
    logic dina;
    logic dinb;
  } exp_t;

  // Expected outputs n cycles after the accepting edge of the current frame.
  function automatic exp_t expect_at(int d, bit a, int n, logic [15:0] wa, logic [15:0] wb);
    exp_t e;
    int dd, g, k;
    dd = dv(d);
    g  = gp(d);
    e  = '{ready: 1'b1, done: 1'b0, sync_n: 1'b1, sclk: 1'b1, dina: 1'b0, dinb: 1'b0};
    if (a) begin
      if (n >= 1 && n <= 32 * dd) begin
        k        = (n - 1) / (2 * dd);
        e.ready  = 1'b0;
        e.sync_n = 1'b0;
        e.sclk   = (((n - 1) / dd) % 2 == 0);
        e.dina   = wa[15 - k];
        e.dinb   = wb[15 - k];
      end else if (n == 32 * dd + 1) begin
        e.ready = 1'b0;
        e.done  = 1'b1;
      end else if (n < 32 * dd + 1 + g) begin
        e.ready = 1'b0;
      end
    end
    return e;
  endfunction

  int          cyc = 0;
  bit          act  [2] = '{0, 0};
  int          tacc [2] = '{0, 0};
  logic [15:0] mwa  [2];
  logic [15:0] mwb  [2];
  bit          chk_en = 0;

  always @(posedge clock) begin
    int n;
    bit mready;
    for (int d = 0; d < 2; d++) begin
      n      = cyc - tacc[d];
      mready = !act[d] || (n >= 32 * dv(d) + 1 + gp(d));
      if (rst[d]) begin
        act[d] = 0;
      end else if (mready && valid[d]) begin
        act[d]  = 1;
        tacc[d] = cyc;
        mwa[d]  = {2'b00, pd[d], sa[d]};
        mwb[d]  = {2'b00, pd[d], sb[d]};
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    exp_t e;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e = expect_at(d, act[d], cyc - tacc[d], mwa[d], mwb[d]);
        chk("ready",  d, rdy[d], e.ready);
        chk("done",   d, dn[d],  e.done);
        chk("sync_n", d, syn[d], e.sync_n);
        chk("sclk",   d, sck[d], e.sclk);
        chk("dina",   d, da[d],  e.dina);
        chk("dinb",   d, db[d],  e.dinb);
      end
    end
  end

  // ---------------- DAC-side capture ----------------
  logic [15:0] cap_a [2];
  logic [15:0] cap_b [2];
  int  nbits    [2] = '{0, 0};
  int  lowcnt   [2] = '{0, 0};
  int  hicnt    [2] = '{0, 0};
  int  last_low [2] = '{0, 0};
  int  last_hi  [2] = '{0, 0};
  int  frames   [2] = '{0, 0};
  int  dones    [2] = '{0, 0};
  logic prev_syn [2] = '{1'b1, 1'b1};
  logic prev_sck [2] = '{1'b1, 1'b1};

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (syn[d] === 1'b0) begin
          if (prev_syn[d] === 1'b1) begin
            frames[d]++;
            last_hi[d] = hicnt[d];
            nbits[d]   = 0;
            lowcnt[d]  = 0;
            cap_a[d]   = '0;
            cap_b[d]   = '0;
          end
          lowcnt[d]++;
          if (prev_sck[d] === 1'b1 && sck[d] === 1'b0) begin
            cap_a[d] = {cap_a[d][14:0], da[d]};
            cap_b[d] = {cap_b[d][14:0], db[d]};
            nbits[d]++;
          end
        end else begin
          if (prev_syn[d] === 1'b0) begin
            last_low[d] = lowcnt[d];
            hicnt[d]    = 0;
          end
          hicnt[d]++;
        end
        if (dn[d] === 1'b1) dones[d]++;
        prev_syn[d] = syn[d];
        prev_sck[d] = sck[d];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(int d);
    int k = 0;
    while (rdy[d] !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 1000) chkv("ready_timeout", d, k, 0);
  endtask

  task automatic request(int d, logic [11:0] a, logic [11:0] b, logic [1:0] p);
    wait_ready(d);
    sa[d]    = a;
    sb[d]    = b;
    pd[d]    = p;
    valid[d] = 1'b1;
    @(negedge clock);
    valid[d] = 1'b0;
  endtask

  // Returns one cycle after done so the capture block has closed the frame.
  task automatic wait_done(int d);
    int k = 0;
    while (dn[d] !== 1'b1 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 2000) chkv("done_timeout", d, k, 0);
    @(negedge clock);
  endtask

  task automatic wait_frames(int d, int target);
    int k = 0;
    while (frames[d] < target && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 2000) chkv("frame_timeout", d, k, 0);
  endtask

  typedef struct {
    int          d;
    logic [11:0] a;
    logic [11:0] b;
    logic [1:0]  p;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int f0;
    int d0;

    vecs[0] = '{d: 0, a: 12'hA5C, b: 12'h3F1, p: 2'b00, exp_a: 16'h0A5C, exp_b: 16'h03F1};
    vecs[1] = '{d: 0, a: 12'h000, b: 12'hFFF, p: 2'b01, exp_a: 16'h1000, exp_b: 16'h1FFF};
    vecs[2] = '{d: 1, a: 12'h800, b: 12'h123, p: 2'b11, exp_a: 16'h3800, exp_b: 16'h3123};
    vecs[3] = '{d: 1, a: 12'hFFF, b: 12'h000, p: 2'b10, exp_a: 16'h2FFF, exp_b: 16'h2000};
    vecs[4] = '{d: 0, a: 12'h555, b: 12'hAAA, p: 2'b10, exp_a: 16'h2555, exp_b: 16'h2AAA};

    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      valid[d] = 1'b1;
      sa[d]    = 12'h123;
      sb[d]    = 12'h456;
      pd[d]    = 2'b00;
    end

    // Reset held with valid high: must stay idle throughout.
    @(posedge clock);
    #1 chk_en = 1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b0;
      valid[d] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) chkv("reset_no_frame", d, frames[d], 0);

    // Table vectors: captured words and frame length.
    foreach (vecs[i]) begin
      request(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].p);
      wait_done(vecs[i].d);
      chkv("word_a",   vecs[i].d, int'(cap_a[vecs[i].d]), int'(vecs[i].exp_a));
      chkv("word_b",   vecs[i].d, int'(cap_b[vecs[i].d]), int'(vecs[i].exp_b));
      chkv("nbits",    vecs[i].d, nbits[vecs[i].d], 16);
      chkv("sync_len", vecs[i].d, last_low[vecs[i].d], 32 * dv(vecs[i].d));
    end

    // Input changes and valid toggling during a frame are ignored.
    f0 = frames[0];
    request(0, 12'hA5C, 12'h3F1, 2'b00);
    for (int i = 0; i < 40; i++) begin
      sa[0]    = 12'hFFF;
      valid[0] = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    valid[0] = 1'b0;
    wait_done(0);
    chkv("stable_word_a", 0, int'(cap_a[0]), 16'h0A5C);
    repeat (6) @(negedge clock);
    chkv("stable_frames", 0, frames[0], f0 + 1);

    // Back-to-back frames with valid held high.
    for (int d = 0; d < 2; d++) begin
      wait_ready(d);
      f0       = frames[d];
      sa[d]    = 12'h000;
      sb[d]    = 12'h000;
      pd[d]    = 2'b00;
      valid[d] = 1'b1;
      @(negedge clock);
      sa[d] = 12'hFFF;
      sb[d] = 12'hFFF;
      wait_done(d);
      chkv("b2b_first_a", d, int'(cap_a[d]), 16'h0000);
      wait_frames(d, f0 + 2);
      valid[d] = 1'b0;
      chkv("b2b_gap", d, last_hi[d], gp(d) + 1);
      wait_done(d);
      chkv("b2b_second_a", d, int'(cap_a[d]), 16'h0FFF);
      chkv("b2b_second_b", d, int'(cap_b[d]), 16'h0FFF);
    end

    // Reset in the middle of a frame.
    d0 = dones[0];
    request(0, 12'h5A5, 12'h1C3, 2'b01);
    begin
      int k = 0;
      while (nbits[0] < 7 && k < 500) begin
        @(negedge clock);
        k++;
      end
      if (k >= 500) chkv("midreset_timeout", 0, k, 0);
    end
    rst[0] = 1'b1;
    @(negedge clock);
    rst[0] = 1'b0;
    chk("midreset_sync_n", 0, syn[0], 1'b1);
    chk("midreset_sclk",   0, sck[0], 1'b1);
    chk("midreset_ready",  0, rdy[0], 1'b1);
    chk("midreset_done",   0, dn[0],  1'b0);
    repeat (10) @(negedge clock);
    chkv("midreset_no_done", 0, dones[0], d0);
    request(0, 12'h7E1, 12'h02A, 2'b10);
    wait_done(0);
    chkv("after_reset_a", 0, int'(cap_a[0]), 16'h27E1);
    chkv("after_reset_b", 0, int'(cap_b[0]), 16'h202A);
    chkv("after_reset_bits", 0, nbits[0], 16);

    // Randomised traffic with occasional resets, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]   = ($urandom_range(0, 299) == 0);
        valid[d] = 1'($urandom_range(0, 1));
        sa[d]    = 12'($urandom);
        sb[d]    = 12'($urandom);
        pd[d]    = 2'($urandom);
      end
      @(negedge clock);
    end
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b0;
      valid[d] = 1'b0;
    end
    repeat (200) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_frame_serializer.md
Name: dac_frame_serializer

Overview:
- Downstream stage of the waveform generators (sawtooth/square/triangle).
- Accepts a pair of 12-bit samples (channel A/B) per request and serialises them to a dual-channel 12-bit SPI-style DAC (PmodDA2-class: SYNC, SCLK, DINA, DINB).
- Each transfer is one 16-bit frame per channel, MSB first, shifted simultaneously on both data lines.
- Provides valid/ready flow control so the generator's sample clock and the DAC frame rate are decoupled.

Parameters:
- CLK_DIV, 4, clock cycles per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 2, clock cycles sync_n is held high after a frame before ready reasserts; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- sample_a  input  12  channel A sample, unsigned
- sample_b  input  12  channel B sample, unsigned
- pd_mode  input  2  DAC power-down control bits, latched with samples
- valid  input  1  upstream asserts when sample_a/sample_b/pd_mode are valid
- ready  output  1  high when block accepts a request
- done  output  1  one-cycle pulse at end of each frame
- sync_n  output  1  DAC frame sync, active low
- sclk  output  1  DAC serial clock, idles high
- dina  output  1  serial data, channel A
- dinb  output  1  serial data, channel B

Behaviour:
- Reset (sampled at posedge): next cycle ready=1, done=0, sync_n=1, sclk=1, dina=0, dinb=0, FSM=IDLE, counters cleared. Reset mid-frame aborts the frame immediately; no done pulse.
- Frame word per channel: {2'b00, pd_mode, sample}. Bits 15:14 zero, 13:12 pd_mode, 11:0 sample. Shifted MSB first.
- Handshake: transfer occurs at posedge T where valid&ready=1. Samples and pd_mode are latched at T. Input changes after T have no effect on the frame. valid while ready=0 is ignored (not queued). ready is registered and depends only on state, never combinationally on valid.
- FSM states: IDLE -> SHIFT -> GAP -> IDLE.
  - IDLE: ready=1, sync_n=1, sclk=1.
  - SHIFT entered at T+1: ready=0, sync_n=0, sclk=1, dina/dinb = bit 15.
  - SCLK timing: sclk toggles every CLK_DIV cycles, via a divider counter 0..CLK_DIV-1. Falling edges occur at T+1+(2k+1)*CLK_DIV, where the DAC samples. Rising edges occur at T+1+(2k+2)*CLK_DIV, where the next bit is presented.
  - Bit k (k=0 is bit 15) is valid on dina/dinb from T+1+2k*CLK_DIV for 2*CLK_DIV cycles.
  - Bit counter counts 16 falling edges, 0..15, 4-bit.
  - At T+1+32*CLK_DIV: sync_n=1, sclk=1, dina=dinb=0, done=1 for exactly this cycle, state=GAP.
  - GAP: ready=0 for GAP_CYCLES cycles. ready=1 again at T+1+32*CLK_DIV+GAP_CYCLES (IDLE).
- Throughput: one frame per 32*CLK_DIV+GAP_CYCLES+1 clock cycles, with valid held high. Back-to-back frames have sync_n high for exactly GAP_CYCLES+1 cycles.
- sclk never glitches. sclk is high whenever sync_n transitions.
- Width rules: divider counter 8 bits, bit counter 4 bits, gap counter 8 bits. No counter may wrap within a frame at maximum parameter values.
- Simultaneous reset and valid: reset wins; no transfer.

Test Plan:
- Reset then idle: assert reset 3 cycles with valid=1 -> ready=1, sync_n=1, sclk=1, dina=dinb=0, done=0 throughout; no frame starts.
- Single frame, CLK_DIV=4, GAP_CYCLES=2: sample_a=12'hA5C, sample_b=12'h3F1, pd_mode=0, accept at T -> sync_n low T+1..T+128. Data captured on 16 sclk falling edges equals 16'h0A5C on dina and 16'h03F1 on dinb. done pulses at T+129. ready=1 at T+131.
- Input stability: change sample_a to 12'hFFF and toggle valid during the frame -> serialised data still 16'h0A5C; no second frame while ready=0.
- Back-to-back: valid held high, samples 12'h000 then 12'hFFF -> two frames; second sync_n falls exactly 3 cycles after the first rises. Second dina word is 16'h0FFF.
- pd_mode and CLK_DIV=1: pd_mode=2'b11, sample_a=12'h800 -> dina word 16'h3800. sclk period is 2 cycles; frame length is 32 cycles of sync_n low.
- Reset mid-frame: assert reset at bit 7 of a frame -> next cycle sync_n=1, sclk=1, ready=1, no done pulse. A new valid request then produces a complete, correct frame.
